// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU datapath definitions used by the register file and its
// clear sequencer.
//   DATA_W_DEF  : default register data width
//   ADDR_W_DEF  : default register address width (16 entries)
//   clr_state_t : clear FSM state encoding (CLR_CLEAR, CLR_RUN)
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        CLR_CLEAR = 1'b0,
        CLR_RUN   = 1'b1
    } clr_state_t;

endpackage : cpu_pkg

// File: rtl/reg_file_clr_fsm.sv
// reg_file_clr_fsm
// Sequencer that walks every register entry and writes zero into it,
// after reset and whenever a clear is requested while running.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr_req   in   single-cycle request to (re)start the clear sequence
//   clr_busy  out  clear sequence in progress (registered)
//   clr_done  out  one-cycle pulse when the last entry has been cleared
//   clr_we    out  clear-write strobe for the storage array
//   clr_addr  out  entry being cleared this cycle
module reg_file_clr_fsm
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    clr_state_t        state;
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLR_CLEAR;
            clr_ptr  <= '0;
            clr_busy <= 1'b1;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                CLR_CLEAR: begin
                    // A new request restarts the walk from entry 0, even
                    // if the current walk was about to finish.
                    if (clr_req) begin
                        clr_ptr <= '0;
                    end else if (clr_ptr == LAST_PTR) begin
                        state    <= CLR_RUN;
                        clr_ptr  <= '0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                CLR_RUN: begin
                    if (clr_req) begin
                        state    <= CLR_CLEAR;
                        clr_ptr  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                default: begin
                    state    <= CLR_CLEAR;
                    clr_ptr  <= '0;
                    clr_busy <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLR_CLEAR);
    assign clr_addr = clr_ptr;

endmodule : reg_file_clr_fsm

// File: rtl/reg_file_p.sv
// reg_file_p
// Parametrised CPU register file: one write port, NUM_RD combinational
// read ports, optional hardwired zero register, optional write-to-read
// bypass, a sequential clear engine and a per-entry "written" scoreboard.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ra         in   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   read_data  out  packed read data, port i at [i*DATA_W +: DATA_W]
//   wa         in   write address
//   wd         in   write data
//   we         in   write enable
//   cpu_paused in   suppresses writes while high
//   clr_req    in   request to re-run the clear sequence
//   clr_busy   out  clear sequence in progress
//   clr_done   out  one-cycle pulse when the clear sequence completes
//   written    out  bit k set when entry k has been written since last clear
module reg_file_p
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     we,
    input  logic                     cpu_paused,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic [(1<<ADDR_W)-1:0]   written
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_commit;

    reg_file_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request in RUN wins over a write in the same cycle, so it
    // also blocks the bypass path; writes during CLEAR are simply dropped.
    assign wr_commit = !clr_busy && !clr_req && we && !cpu_paused &&
                       !((ZERO_REG != 0) && (wa == '0));

    // Storage is deliberately not reset: the clear engine zeroes it after
    // every reset before any read can observe it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else if (clr_busy || clr_req) begin
            written <= '0;
        end else if (wr_commit) begin
            written[wa] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra_g;
        logic [DATA_W-1:0] rd_g;

        assign ra_g = ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            rd_g = mem[ra_g];
            if (clr_busy) begin
                rd_g = '0;
            end else if ((ZERO_REG != 0) && (ra_g == '0)) begin
                rd_g = '0;
            end else if ((BYPASS != 0) && wr_commit && (wa == ra_g)) begin
                rd_g = wd;
            end
        end

        assign read_data[g*DATA_W +: DATA_W] = rd_g;
    end

endmodule : reg_file_p

// File: tb/tb_reg_file_p.sv
// tb_reg_file_p
// Directed testbench for reg_file_p. Two instances share all inputs:
//   dut    : defaults (ZERO_REG = 1, BYPASS = 1)
//   dut_nb : ZERO_REG = 0, BYPASS = 0
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_reg_file_p;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ra;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        we;
    logic        cpu_paused;
    logic        clr_req;

    logic [15:0] read_data;
    logic        clr_busy;
    logic        clr_done;
    logic [15:0] written;

    logic [15:0] nb_read_data;
    logic        nb_clr_busy;
    logic        nb_clr_done;
    logic [15:0] nb_written;

    int checks = 0;
    int errors = 0;

    reg_file_p dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra         (ra),
        .read_data  (read_data),
        .wa         (wa),
        .wd         (wd),
        .we         (we),
        .cpu_paused (cpu_paused),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .written    (written)
    );

    reg_file_p #(
        .ZERO_REG (0),
        .BYPASS   (0)
    ) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra         (ra),
        .read_data  (nb_read_data),
        .wa         (wa),
        .wd         (wd),
        .we         (we),
        .cpu_paused (cpu_paused),
        .clr_req    (clr_req),
        .clr_busy   (nb_clr_busy),
        .clr_done   (nb_clr_done),
        .written    (nb_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives all inputs, then waits 1 ns so combinational reads settle.
    task automatic applyStimulus(input logic i_we, input logic [3:0] i_wa,
                                 input logic [7:0] i_wd, input logic [3:0] i_ra0,
                                 input logic [3:0] i_ra1, input logic i_paused,
                                 input logic i_clr);
        we         = i_we;
        wa         = i_wa;
        wd         = i_wd;
        ra         = {i_ra1, i_ra0};
        cpu_paused = i_paused;
        clr_req    = i_clr;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Expects the 16-edge clear walk starting now on both instances.
    task automatic checkClearSequence(input string tag);
        for (int i = 0; i < 16; i++) begin
            checkOutput({tag, "_busy"},    clr_busy,     1'b1);
            checkOutput({tag, "_nb_busy"}, nb_clr_busy,  1'b1);
            checkOutput({tag, "_done"},    clr_done,     1'b0);
            checkOutput({tag, "_rd"},      read_data,    16'h0000);
            checkOutput({tag, "_nb_rd"},   nb_read_data, 16'h0000);
            checkOutput({tag, "_written"}, written,      16'h0000);
            stepClock();
        end
        checkOutput({tag, "_busy_end"},   clr_busy,    1'b0);
        checkOutput({tag, "_done_pulse"}, clr_done,    1'b1);
        checkOutput({tag, "_nb_done"},    nb_clr_done, 1'b1);
        stepClock();
        checkOutput({tag, "_done_drop"},  clr_done,    1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd5, 4'd1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rst_busy",    clr_busy, 1'b1);
        checkOutput("rst_done",    clr_done, 1'b0);
        checkOutput("rst_written", written,  16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkClearSequence("clr_reset");

        // Plain write, then both ports read the same entry.
        applyStimulus(1'b1, 4'd5, 8'hA7, 4'd0, 4'd0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0, 1'b0);
        checkOutput("wr5_rd",      read_data,    16'hA7A7);
        checkOutput("wr5_nb_rd",   nb_read_data, 16'hA7A7);
        checkOutput("wr5_written", written,      16'h0020);

        // Same-cycle write/read of entry 3: bypass vs stored value.
        applyStimulus(1'b1, 4'd3, 8'h3C, 4'd3, 4'd5, 1'b0, 1'b0);
        checkOutput("byp_rd",    read_data,    16'hA73C);
        checkOutput("nobyp_rd",  nb_read_data, 16'hA700);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd3, 4'd5, 1'b0, 1'b0);
        checkOutput("byp_next",   read_data,    16'hA73C);
        checkOutput("nobyp_next", nb_read_data, 16'hA73C);
        checkOutput("byp_written", written,     16'h0028);

        // Write to entry 0: hardwired zero vs ordinary register.
        applyStimulus(1'b1, 4'd0, 8'hFF, 4'd0, 4'd3, 1'b0, 1'b0);
        checkOutput("zero_same",   read_data, 16'h3C00);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd0, 4'd3, 1'b0, 1'b0);
        checkOutput("zero_rd",        read_data,    16'h3C00);
        checkOutput("nozero_rd",      nb_read_data, 16'h3CFF);
        checkOutput("zero_written",   written,      16'h0028);
        checkOutput("nozero_written", nb_written,   16'h0029);

        // Paused write is suppressed.
        applyStimulus(1'b1, 4'd7, 8'h55, 4'd7, 4'd7, 1'b1, 1'b0);
        checkOutput("pause_same", read_data, 16'h0000);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd7, 4'd7, 1'b0, 1'b0);
        checkOutput("pause_rd",      read_data,    16'h0000);
        checkOutput("pause_nb_rd",   nb_read_data, 16'h0000);
        checkOutput("pause_written", written,      16'h0028);

        // Fill entries 1 and 2.
        applyStimulus(1'b1, 4'd1, 8'h11, 4'd1, 4'd2, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 4'd2, 8'h22, 4'd1, 4'd2, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd1, 4'd2, 1'b0, 1'b0);
        checkOutput("fill_rd",      read_data, 16'h2211);
        checkOutput("fill_written", written,   16'h002E);

        // Clear request wins over a simultaneous write to entry 4.
        applyStimulus(1'b1, 4'd4, 8'h44, 4'd1, 4'd2, 1'b0, 1'b1);
        checkOutput("clrreq_no_byp", read_data, 16'h2211);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd1, 4'd2, 1'b0, 1'b0);
        checkClearSequence("clr_req");
        checkOutput("after_clr_rd12", read_data,    16'h0000);
        checkOutput("after_clr_nb",   nb_read_data, 16'h0000);
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd4, 4'd5, 1'b0, 1'b0);
        checkOutput("after_clr_rd45", read_data,    16'h0000);
        checkOutput("after_clr_wr",   written,      16'h0000);
        checkOutput("after_clr_nbwr", nb_written,   16'h0000);

        // Reset in the middle of a clear restarts a full 16-cycle walk.
        applyStimulus(1'b1, 4'd9, 8'h99, 4'd9, 4'd9, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) stepClock();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",    clr_busy, 1'b1);
        checkOutput("midrst_done",    clr_done, 1'b0);
        checkOutput("midrst_written", written,  16'h0000);
        stepClock();
        checkOutput("midrst_hold_done", clr_done, 1'b0);
        rst_n = 1'b1;
        #1;
        checkClearSequence("clr_midrst");
        checkOutput("midrst_rd9", read_data, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_p

// File: doc/reg_file_p.md
Name: reg_file_p

Overview:
Parametrised successor to the CPU's 8-bit, 16-entry register file. It provides:
- Configurable data width, depth and number of read ports.
- An optional hardwired zero register.
- Optional same-cycle write-to-read bypass.
- A sequential clear engine that zeroes the array after reset or on request.
- A per-register "written" scoreboard.

It sits between decode (read addresses) and writeback (write port) in the CPU datapath.

Parameters:
DATA_W, 8, register data width in bits
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register
BYPASS, 1, 1 = a read of the address being written this cycle returns wd; 0 = returns the stored value

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ra  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
read_data  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
we  in  1  write enable
cpu_paused  in  1  when 1, writes are suppressed
clr_req  in  1  single-cycle request to re-run the clear sequence
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse on the cycle the clear sequence completes
written  out  DEPTH  bit k = entry k written since the last clear

Behaviour:
- Reset state (rst_n low): state = CLEAR, clr_ptr = 0, clr_busy = 1, clr_done = 0, written = 0. The storage array itself is not reset.
- States:
  - CLEAR: each rising edge writes 0 to entry clr_ptr, then clr_ptr increments.
  - On the edge that clears entry DEPTH-1: go to RUN, clr_busy <= 0, clr_done <= 1 for one cycle.
- Clear timing: clr_busy stays high for exactly DEPTH rising edges after rst_n deasserts.
- During CLEAR:
  - All read_data ports return 0.
  - Writes are dropped, not queued.
  - clr_req restarts clearing with clr_ptr = 0.
- RUN:
  - Write commit condition: we && !cpu_paused && !(ZERO_REG && wa == 0).
  - When the condition holds, entry wa <= wd and written[wa] <= 1 on the rising edge.
  - clr_req in RUN: next state CLEAR, clr_ptr = 0, written <= 0. A write in that same cycle is dropped (clear wins).
- Reads are combinational, with zero cycles of latency.
  - ZERO_REG = 1 and ra_i == 0 -> 0.
  - BYPASS = 1 and the write commit condition holds with wa == ra_i -> wd.
  - Otherwise -> the stored entry.
- Multiple read ports may address the same entry; each port gets the identical value.
- With ZERO_REG = 1, written[0] is permanently 0.
- Asserting rst_n mid-clear or mid-run returns everything to the reset state immediately. Partially written array contents are irrelevant because a full clear follows.
- clr_done is a registered output and never asserts while rst_n is low.

Decomposition:
- Shared package (cpu_pkg):
  - Default DATA_W and ADDR_W constants.
  - State encoding for the clear FSM: CLR_CLEAR, CLR_RUN.
- Natural sub-module: reg_file_clr_fsm. It owns state, clr_ptr, clr_busy and clr_done, and outputs a clear-write strobe plus address. The top level owns the array, the written vector, the read muxes and the bypass.

Test Plan:
- Reset release, defaults -> clr_busy = 1 for exactly 16 cycles. clr_done pulses once on cycle 16. All read_data = 0 throughout. written = 16'h0000.
- In RUN, write wa = 5, wd = 8'hA7, then read ra0 = 5, ra1 = 5 next cycle -> both ports read 8'hA7, written = 16'h0020.
- Write wa = 3, wd = 8'h3C, we = 1 with ra0 = 3 in the same cycle, BYPASS = 1 -> read_data port 0 = 8'h3C that cycle. Repeat with BYPASS = 0 -> old value (8'h00) that cycle, 8'h3C next cycle.
- Write wa = 0, wd = 8'hFF with ZERO_REG = 1 -> ra0 = 0 reads 8'h00 and written[0] = 0. Same write with ZERO_REG = 0 -> reads 8'hFF.
- Write wa = 7, wd = 8'h55 with cpu_paused = 1 -> entry 7 unchanged (8'h00), written[7] = 0.
- Entries 1, 2 hold 8'h11, 8'h22; assert clr_req together with a write to wa = 4 -> the write is dropped, clr_busy = 1 for 16 cycles, then entries 1, 2, 4 read 8'h00 and written = 0. Pulse rst_n low at clear cycle 6 -> the clear restarts from clr_ptr = 0 for a full 16 cycles.
